// File: rtl/controller_pkg.sv
// Shared constants and types for the NES controller poller: button bit
// positions, FSM state encoding and default phase timing.
package controller_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int LATCH_CYCLES_DEF = 300;
  localparam int HALF_CYCLES_DEF  = 150;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_controller_reader_if.sv
// Controller-side and consumer-side signals of the poller, bundled so the
// reader and its environment connect through one port.
interface nes_controller_reader_if;
  logic       poll_start;
  logic       ctrl_data;
  logic       ctrl_latch;
  logic       ctrl_pulse;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       busy;

  modport master (
    output poll_start, ctrl_data,
    input  ctrl_latch, ctrl_pulse, buttons, pressed, valid, busy
  );

  modport slave (
    input  poll_start, ctrl_data,
    output ctrl_latch, ctrl_pulse, buttons, pressed, valid, busy
  );
endinterface

// File: rtl/nes_controller_reader_sync2.sv
// Two-flop synchronizer for the asynchronous controller data line; resets
// to 1 because the line idles high.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/nes_controller_reader.sv
// Polls a serial NES controller once per poll_start and publishes a
// two-poll debounced button level plus a one-cycle press-edge vector.
module nes_controller_reader
  import controller_pkg::*;
#(
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF,
  parameter int HALF_CYCLES  = HALF_CYCLES_DEF
) (
  input  logic                    clk25,
  input  logic                    reset,
  nes_controller_reader_if.slave  bus
);
  localparam int CNT_MAX = max_int(LATCH_CYCLES, HALF_CYCLES);
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       raw_q;
  logic [7:0]       prev_raw_q;
  logic [7:0]       buttons_q;
  logic [7:0]       pressed_q;
  logic             valid_q;
  logic             busy_q;
  logic             latch_q;
  logic             pulse_q;
  logic             data_sync_s;
  logic             data_raw_s;
  logic [7:0]       buttons_d;

  sync2 u_sync2 (
    .clk_i (clk25),
    .rst_i (reset),
    .d_i   (bus.ctrl_data),
    .q_o   (data_sync_s)
  );

  // Controller line is active-low: a pressed button reads as 0.
  assign data_raw_s = ~data_sync_s;

  always_comb begin
    buttons_d = buttons_q;
    if (raw_q == prev_raw_q) begin
      buttons_d = raw_q;
    end else begin
      buttons_d = buttons_q;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      raw_q      <= 8'h00;
      prev_raw_q <= 8'h00;
      buttons_q  <= 8'h00;
      pressed_q  <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      pressed_q <= 8'h00;
      case (state_q)
        ST_IDLE: begin
          if (bus.poll_start) begin
            state_q   <= ST_LATCH;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            latch_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (cnt_q == LATCH_LAST) begin
            cnt_q   <= '0;
            latch_q <= 1'b0;
            state_q <= ST_LOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // Sample on the last LOW cycle, long after the synchronizer settled.
        ST_LOW: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q            <= '0;
            raw_q[bit_idx_q] <= data_raw_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_HIGH;
              pulse_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            bit_idx_q <= bit_idx_q + 3'd1;
            state_q   <= ST_LOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          buttons_q  <= buttons_d;
          prev_raw_q <= raw_q;
          pressed_q  <= buttons_d & ~buttons_q;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          latch_q <= 1'b0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_pulse = pulse_q;
  assign bus.buttons    = buttons_q;
  assign bus.pressed    = pressed_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
endmodule
